// File: rtl/avst_video_pkg.sv
// Shared types and constants for the Avalon-ST video pattern generator.
package avst_video_pkg;

    // Runtime pattern select, encoded to match the 2-bit mode input.
    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_SOLID   = 2'd3
    } pat_mode_t;

    // Frame sequencer state; ST_ACTIVE is also what busy reports.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } gen_state_t;

    // Colour-bar RGB codes indexed by bar number (bit 2 = R, bit 1 = G, bit 0 = B).
    // Listed from entry 7 down to entry 0:
    // black, blue, red, magenta, green, cyan, yellow, white.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/avst_video_pixel_fn.sv
// Combinational pixel function: (mode, x, y, bar, solid colour) -> one pixel.
module avst_video_pixel_fn
    import avst_video_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int CHK_LOG2 = 4
) (
    input  pat_mode_t                     i_mode,
    input  logic [XW-1:0]                 i_x,
    input  logic [YW-1:0]                 i_y,
    input  logic [2:0]                    i_bar,
    input  logic [DATA_W*CHANNELS-1:0]    i_solid,
    output logic [DATA_W*CHANNELS-1:0]    o_pixel
);

    logic [2:0]        w_code;
    logic [DATA_W-1:0] w_ramp;
    logic              w_chk;

    assign w_code = BAR_RGB[i_bar];
    // Ramp uses the low DATA_W bits of x, so it wraps modulo 2**DATA_W.
    assign w_ramp = DATA_W'(i_x);
    // Checker square parity: LSB of the square index in each direction.
    assign w_chk  = 1'(i_x >> CHK_LOG2) ^ 1'(i_y >> CHK_LOG2);

    // Select the pattern; channels beyond RGB reuse the code bits cyclically.
    always_comb begin
        o_pixel = '0;
        case (i_mode)
            PAT_BARS: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_code[c % 3]) begin
                        o_pixel[c*DATA_W +: DATA_W] = '1;
                    end
                end
            end
            PAT_RAMP: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    o_pixel[c*DATA_W +: DATA_W] = w_ramp;
                end
            end
            PAT_CHECKER: begin
                if (w_chk) begin
                    o_pixel = '1;
                end
            end
            PAT_SOLID: begin
                o_pixel = i_solid;
            end
            default: begin
                o_pixel = '0;
            end
        endcase
    end

endmodule

// File: rtl/avst_video_pattern_gen.sv
// Avalon-ST video source: whole frames of H_ACTIVE x V_ACTIVE pixels with
// sop/eop framing, runtime pattern select and sink backpressure.
//
// Handshake: a beat transfers on a clock edge where src_valid and src_ready
// are both high (readyLatency 0). While src_valid is high and src_ready is
// low, src_data, src_startofpacket and src_endofpacket hold their values.
// Inside a frame src_valid never drops.
module avst_video_pattern_gen
    import avst_video_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CHK_LOG2 = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic [DATA_W*CHANNELS-1:0]    solid_color,
    output logic [DATA_W*CHANNELS-1:0]    src_data,
    output logic                          src_valid,
    input  logic                          src_ready,
    output logic                          src_startofpacket,
    output logic                          src_endofpacket,
    output logic                          busy,
    output logic [15:0]                   frame_count
);

    localparam int PIX_W   = DATA_W * CHANNELS;
    localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BAR_LEN - 1);

    gen_state_t        r_state;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [2:0]        r_bar;
    logic [BW-1:0]     r_bar_cnt;
    pat_mode_t         r_mode;
    logic [PIX_W-1:0]  r_solid;
    logic [PIX_W-1:0]  r_data;
    logic              r_valid;
    logic              r_sop;
    logic              r_eop;
    logic              r_busy;
    logic [15:0]       r_frame_count;

    logic              w_xfer;
    logic              w_frame_end;
    logic              w_start;
    logic [XW-1:0]     w_nx;
    logic [YW-1:0]     w_ny;
    logic [2:0]        w_nbar;
    logic [BW-1:0]     w_nbar_cnt;
    pat_mode_t         w_nmode;
    logic [PIX_W-1:0]  w_nsolid;
    logic              w_next_sop;
    logic              w_next_eop;
    logic [PIX_W-1:0]  w_pixel;

    assign w_xfer      = r_valid & src_ready;
    assign w_frame_end = (r_state == ST_ACTIVE) && w_xfer && (r_x == X_LAST) && (r_y == Y_LAST);
    // A frame starts from IDLE or back-to-back at the end of the previous one.
    assign w_start     = enable && ((r_state == ST_IDLE) || w_frame_end);
    assign w_next_sop  = (w_nx == '0) && (w_ny == '0);
    assign w_next_eop  = (w_nx == X_LAST) && (w_ny == Y_LAST);

    // Next-position logic; pixels are generated from these so data is ready with valid.
    always_comb begin
        w_nx       = r_x;
        w_ny       = r_y;
        w_nbar     = r_bar;
        w_nbar_cnt = r_bar_cnt;
        w_nmode    = r_mode;
        w_nsolid   = r_solid;
        if (w_start) begin
            w_nx       = '0;
            w_ny       = '0;
            w_nbar     = '0;
            w_nbar_cnt = '0;
            w_nmode    = pat_mode_t'(mode);
            w_nsolid   = solid_color;
        end else if (w_xfer) begin
            if (r_x == X_LAST) begin
                w_nx       = '0;
                w_nbar     = '0;
                w_nbar_cnt = '0;
                w_ny       = (r_y == Y_LAST) ? '0 : r_y + YW'(1);
            end else begin
                w_nx = r_x + XW'(1);
                if (r_bar_cnt == BC_LAST) begin
                    w_nbar_cnt = '0;
                    w_nbar     = r_bar + 3'd1;
                end else begin
                    w_nbar_cnt = r_bar_cnt + BW'(1);
                end
            end
        end
    end

    avst_video_pixel_fn #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .XW       (XW),
        .YW       (YW),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pixel_fn (
        .i_mode  (w_nmode),
        .i_x     (w_nx),
        .i_y     (w_ny),
        .i_bar   (w_nbar),
        .i_solid (w_nsolid),
        .o_pixel (w_pixel)
    );

    // Frame sequencer FSM with registered stream outputs and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_bar         <= '0;
            r_bar_cnt     <= '0;
            r_mode        <= PAT_BARS;
            r_solid       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_x       <= w_nx;
            r_y       <= w_ny;
            r_bar     <= w_nbar;
            r_bar_cnt <= w_nbar_cnt;
            r_mode    <= w_nmode;
            r_solid   <= w_nsolid;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_ACTIVE;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_data  <= w_pixel;
                        r_sop   <= w_next_sop;
                        r_eop   <= w_next_eop;
                    end
                end
                ST_ACTIVE: begin
                    if (w_xfer) begin
                        if (w_frame_end) begin
                            r_frame_count <= r_frame_count + 16'd1;
                        end
                        if (w_frame_end && !enable) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_data  <= '0;
                            r_sop   <= 1'b0;
                            r_eop   <= 1'b0;
                        end else begin
                            r_data <= w_pixel;
                            r_sop  <= w_next_sop;
                            r_eop  <= w_next_eop;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign src_data          = r_data;
    assign src_valid         = r_valid;
    assign src_startofpacket = r_sop;
    assign src_endofpacket   = r_eop;
    assign busy              = r_busy;
    assign frame_count       = r_frame_count;

endmodule

// File: tb/tb_avst_video_pattern_gen.sv
// Scoreboard bench for avst_video_pattern_gen with a 16x4 frame.
module tb_avst_video_pattern_gen;

    localparam int DATA_W   = 8;
    localparam int CHANNELS = 3;
    localparam int H        = 16;
    localparam int V        = 4;
    localparam int CHK      = 2;
    localparam int PIX_W    = DATA_W * CHANNELS;
    localparam int EW       = PIX_W + 2;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic [PIX_W-1:0] solid_color;
    logic [PIX_W-1:0] src_data;
    logic             src_valid;
    logic             src_ready;
    logic             src_startofpacket;
    logic             src_endofpacket;
    logic             busy;
    logic [15:0]      frame_count;

    always #5 clk = ~clk;

    avst_video_pattern_gen #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CHK_LOG2 (CHK)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .mode              (mode),
        .solid_color       (solid_color),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .busy              (busy),
        .frame_count       (frame_count)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]    exp_q[$];
    logic [PIX_W-1:0] cap_data[$];
    logic             cap_sop[$];
    logic             cap_eop[$];
    int               checks = 0;
    int               errors = 0;
    int               xfer_cnt = 0;
    int               stall_checks = 0;
    int               gap_cnt = 0;
    bit               gap_watch = 0;
    bit               prev_stall = 0;
    logic [EW-1:0]    prev_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference pixel straight from the pattern definitions.
    function automatic logic [PIX_W-1:0] model_pixel(input int md, input int x, input int y,
                                                     input logic [PIX_W-1:0] solid);
        logic [7:0] xb;
        xb = 8'(x);
        case (md)
            0: begin
                case (x / (H / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return {xb, xb, xb};
            2: return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return solid;
        endcase
    endfunction

    // Push the expected first n beats of a frame.
    task automatic push_beats(input int md, input logic [PIX_W-1:0] solid, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == 0), (i == H*V-1), model_pixel(md, i % H, i / H, solid)});
        end
    endtask

    // ---------------- monitor ----------------
    task automatic monitor_loop();
        logic [EW-1:0] got;
        logic [EW-1:0] want;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
            end else begin
                got = {src_startofpacket, src_endofpacket, src_data};
                if (prev_stall && src_valid) begin
                    stall_checks++;
                    chk("stall_hold", 64'(got), 64'(prev_word));
                end
                if (gap_watch && !src_valid) gap_cnt++;
                if (src_valid && src_ready) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("beat_expected_%0d", xfer_cnt), 64'd0, 64'd1);
                    end else begin
                        want = exp_q.pop_front();
                        chk($sformatf("beat_%0d", xfer_cnt), 64'(got), 64'(want));
                    end
                    cap_data.push_back(src_data);
                    cap_sop.push_back(src_startofpacket);
                    cap_eop.push_back(src_endofpacket);
                    xfer_cnt++;
                end
                prev_stall = src_valid && !src_ready;
                prev_word  = got;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse_enable();
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input bit rnd, input string name);
        int n;
        n = 0;
        while (xfer_cnt < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (rnd) src_ready = 1'($urandom_range(0, 1));
        end
        chk({name, "_reached"}, 64'(xfer_cnt >= target), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int sops;
        reset       = 1'b1;
        enable      = 1'b0;
        mode        = 2'd0;
        solid_color = '0;
        src_ready   = 1'b1;
        fork
            monitor_loop();
        join_none

        // Reset state
        do_reset();
        chk("rst_valid", 64'(src_valid), 64'd0);
        chk("rst_sop", 64'(src_startofpacket), 64'd0);
        chk("rst_eop", 64'(src_endofpacket), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(src_data), 64'd0);
        chk("rst_fcount", 64'(frame_count), 64'd0);

        // Colour bars, ready high, one-cycle enable pulse
        base = xfer_cnt;
        mode = 2'd0;
        push_beats(0, '0, H*V);
        pulse_enable();
        chk("bars_valid_rise", 64'(src_valid), 64'd1);
        chk("bars_busy", 64'(busy), 64'd1);
        wait_xfers(base + H*V, 1'b0, "bars");
        repeat (3) @(posedge clk);
        #1;
        chk("bars_beats", 64'(xfer_cnt - base), 64'd64);
        chk("bars_sop0", 64'(cap_sop[base]), 64'd1);
        chk("bars_eop63", 64'(cap_eop[base+63]), 64'd1);
        chk("bars_eop62", 64'(cap_eop[base+62]), 64'd0);
        chk("bars_b0", 64'(cap_data[base+0]), 64'hFFFFFF);
        chk("bars_b1", 64'(cap_data[base+1]), 64'hFFFFFF);
        chk("bars_b2", 64'(cap_data[base+2]), 64'hFFFF00);
        chk("bars_b3", 64'(cap_data[base+3]), 64'hFFFF00);
        chk("bars_b14", 64'(cap_data[base+14]), 64'h000000);
        chk("bars_b15", 64'(cap_data[base+15]), 64'h000000);
        chk("bars_fcount", 64'(frame_count), 64'd1);
        chk("bars_busy_fall", 64'(busy), 64'd0);
        chk("bars_idle_valid", 64'(src_valid), 64'd0);

        // Ramp under random backpressure
        base = xfer_cnt;
        mode = 2'd1;
        push_beats(1, '0, H*V);
        pulse_enable();
        wait_xfers(base + H*V, 1'b1, "ramp");
        src_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ramp_stalls_seen", 64'(stall_checks > 0), 64'd1);
        chk("ramp_b15", 64'(cap_data[base+15]), 64'h0F0F0F);
        chk("ramp_b17", 64'(cap_data[base+17]), 64'h010101);
        chk("ramp_fcount", 64'(frame_count), 64'd2);

        // Checker with 4-pixel squares
        base = xfer_cnt;
        mode = 2'd2;
        push_beats(2, '0, H*V);
        pulse_enable();
        wait_xfers(base + H*V, 1'b0, "chk");
        repeat (3) @(posedge clk);
        #1;
        chk("chk_0_0", 64'(cap_data[base+0]), 64'h000000);
        chk("chk_4_0", 64'(cap_data[base+4]), 64'hFFFFFF);
        chk("chk_0_3", 64'(cap_data[base+48]), 64'h000000);
        chk("chk_5_3", 64'(cap_data[base+53]), 64'hFFFFFF);
        chk("chk_fcount", 64'(frame_count), 64'd3);

        // Three back-to-back frames, mode 3 -> 1 switched mid frame 2
        do_reset();
        chk("b2b_fcount_rst", 64'(frame_count), 64'd0);
        base = xfer_cnt;
        mode = 2'd3;
        solid_color = 24'h123456;
        push_beats(3, 24'h123456, H*V);
        push_beats(3, 24'h123456, H*V);
        push_beats(1, '0, H*V);
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        chk("b2b_valid_rise", 64'(src_valid), 64'd1);
        gap_watch = 1'b1;
        wait_xfers(base + 84, 1'b0, "b2b_mid2");
        mode = 2'd1;
        wait_xfers(base + 133, 1'b0, "b2b_mid3");
        enable = 1'b0;
        wait_xfers(base + 192, 1'b0, "b2b_end");
        gap_watch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sops = 0;
        for (int i = base; i < base + 192; i++) sops += int'(cap_sop[i]);
        chk("b2b_gap", 64'(gap_cnt), 64'd0);
        chk("b2b_sops", 64'(sops), 64'd3);
        chk("b2b_f2_solid", 64'(cap_data[base+94]), 64'h123456);
        chk("b2b_f3_ramp", 64'(cap_data[base+133]), 64'h050505);
        chk("b2b_fcount", 64'(frame_count), 64'd3);

        // Enable dropped at beat 10: frame still completes
        base = xfer_cnt;
        mode = 2'd0;
        push_beats(0, '0, H*V);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_xfers(base + 10, 1'b0, "drop_b10");
        enable = 1'b0;
        wait_xfers(base + H*V, 1'b0, "drop_end");
        repeat (4) @(posedge clk);
        #1;
        chk("drop_beats", 64'(xfer_cnt - base), 64'd64);
        chk("drop_eop63", 64'(cap_eop[base+63]), 64'd1);
        chk("drop_valid", 64'(src_valid), 64'd0);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_fcount", 64'(frame_count), 64'd4);

        // Reset at beat 20 while stalled
        base = xfer_cnt;
        mode = 2'd0;
        push_beats(0, '0, 20);
        pulse_enable();
        wait_xfers(base + 20, 1'b0, "rst20");
        src_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst20_valid", 64'(src_valid), 64'd0);
        chk("rst20_fcount", 64'(frame_count), 64'd0);
        chk("rst20_busy", 64'(busy), 64'd0);
        chk("rst20_beats", 64'(xfer_cnt - base), 64'd20);
        src_ready = 1'b1;
        base = xfer_cnt;
        push_beats(0, '0, H*V);
        pulse_enable();
        chk("fresh_sop", 64'(src_startofpacket), 64'd1);
        wait_xfers(base + H*V, 1'b0, "fresh");
        repeat (3) @(posedge clk);
        #1;
        chk("fresh_fcount", 64'(frame_count), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case the sequence above stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
